// File: rtl/display_scan_controller_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scan path.
// Leading-zero blanking helper is used only when SCAN_BLANK_LEADING_ZERO_EN is defined.
package display_scan_controller_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam int NIBBLE_W   = 4;
    localparam int DATA_W     = NUM_DIGITS * NIBBLE_W;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef logic [SEL_W-1:0]      sel_t;
    typedef logic [NUM_DIGITS-1:0] anode_t;
    typedef logic [DATA_W-1:0]     digits_t;

    // Active-low one-hot enable for the selected digit.
    function automatic anode_t digit_anode(input sel_t s);
        return ~(4'b0001 << s);
    endfunction

    // Bits set to 1 force the matching anode off; digit 0 always stays lit.
    function automatic anode_t leading_zero_mask(input digits_t q);
        anode_t m;
        m[3] = (q[15:12] == 4'h0);
        m[2] = (q[15:8]  == 8'h00);
        m[1] = (q[15:4]  == 12'h000);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/display_scan_controller_tick_divider.sv
// Parameterised prescaler producing a one-cycle scan tick every DIV enabled cycles.
// clr restarts the count at 0; the count holds while en is low.
module tick_divider #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_r;

    assign tick = en && (count_r == CNT_MAX);

    // Prescaler counter: clear has priority, wraps on tick, freezes when disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (tick) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Digit scan controller: steps sel 0..3 on each tick, drives active-low anodes and
// keeps a frame-stable data snapshot. Optional macro: SCAN_BLANK_LEADING_ZERO_EN.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        restart,
    input  logic [15:0] data_in,
    output logic [15:0] data_q,
    output logic [1:0]  sel,
    output logic [3:0]  anode,
    output logic        frame_done
);

    logic    tick_s;
    sel_t    sel_r,        sel_next_s;
    digits_t data_q_r,     data_next_s;
    anode_t  anode_r,      anode_next_s;
    logic    frame_done_r, frame_done_next_s;

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (restart),
        .tick  (tick_s)
    );

    // Next-state: restart beats tick, and only a tick at digit 3 closes a frame.
    always_comb begin
        sel_next_s        = sel_r;
        data_next_s       = data_q_r;
        frame_done_next_s = 1'b0;
        if (restart) begin
            sel_next_s  = '0;
            data_next_s = data_in;
        end else if (tick_s) begin
            sel_next_s = sel_r + SEL_W'(1);
            if (sel_r == SEL_W'(NUM_DIGITS - 1)) begin
                data_next_s       = data_in;
                frame_done_next_s = 1'b1;
            end else begin
                frame_done_next_s = 1'b0;
            end
        end else begin
            sel_next_s = sel_r;
        end

        // Anode follows sel_next so both update on the same edge.
        if (en) begin
`ifdef SCAN_BLANK_LEADING_ZERO_EN
            anode_next_s = digit_anode(sel_next_s) | leading_zero_mask(data_next_s);
`else
            anode_next_s = digit_anode(sel_next_s);
`endif
        end else begin
            anode_next_s = ANODE_OFF;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r        <= '0;
            data_q_r     <= '0;
            anode_r      <= ANODE_OFF;
            frame_done_r <= 1'b0;
        end else begin
            sel_r        <= sel_next_s;
            data_q_r     <= data_next_s;
            anode_r      <= anode_next_s;
            frame_done_r <= frame_done_next_s;
        end
    end

    assign sel        = sel_r;
    assign data_q     = data_q_r;
    assign anode      = anode_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: directed steps plus random stimulus
// compared against an arithmetic reference model (phase counter within a frame).
module tb_display_scan_controller;

`ifdef SCAN_BLANK_LEADING_ZERO_EN
    localparam int DIV = 1;
`else
    localparam int DIV = 4;
`endif
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        restart;
    logic [15:0] data_in;
    logic [15:0] data_q;
    logic [1:0]  sel;
    logic [3:0]  anode;
    logic        frame_done;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: position inside the frame, in enabled clk cycles.
    int          m_phase;
    logic [15:0] m_dq;
    logic        m_fd;
    logic [3:0]  m_anode;

    always #5 clk = ~clk;

    display_scan_controller #(.DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .restart    (restart),
        .data_in    (data_in),
        .data_q     (data_q),
        .sel        (sel),
        .anode      (anode),
        .frame_done (frame_done)
    );

    function automatic int m_sel();
        return m_phase / DIV;
    endfunction

    function automatic logic [3:0] ref_anode(input int dg, input logic [15:0] q);
        logic [3:0] a;
        a = 4'b1111;
        a[dg] = 1'b0;
`ifdef SCAN_BLANK_LEADING_ZERO_EN
        if (dg > 0 && (q >> (4 * dg)) == 16'h0000) a = 4'b1111;
`endif
        return a;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_dq    = 16'h0000;
        m_fd    = 1'b0;
        m_anode = 4'b1111;
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [15:0] d);
        if (r) begin
            model_reset();
        end else if (restart) begin
            m_phase = 0;
            m_dq    = d;
            m_fd    = 1'b0;
            m_anode = e ? ref_anode(0, m_dq) : 4'b1111;
        end else if (e) begin
            m_phase = (m_phase + 1) % FRAME;
            m_fd    = (m_phase == 0);
            if (m_fd) m_dq = d;
            m_anode = ref_anode(m_sel(), m_dq);
        end else begin
            m_fd    = 1'b0;
            m_anode = 4'b1111;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("sel",        {14'd0, sel},        16'(m_sel()));
        check("anode",      {12'd0, anode},      {12'd0, m_anode});
        check("data_q",     data_q,              m_dq);
        check("frame_done", {15'd0, frame_done}, {15'd0, m_fd});
    endtask

    task automatic step(input logic e, input logic r, input logic [15:0] d);
        en      = e;
        restart = r;
        data_in = d;
        @(posedge clk);
        model_edge(reset, e, d);
        #1;
        check_all();
    endtask

    task automatic advance_to_sel(input int target, input logic [15:0] d);
        int n;
        n = 0;
        while (m_sel() != target && n < 64) begin
            step(1'b1, 1'b0, d);
            n++;
        end
        if (m_sel() != target) begin
            compared++;
            mismatched++;
            $error("FAIL advance_timeout: observed sel %0d expected %0d", m_sel(), target);
        end
    endtask

    initial begin
        int          fd_seen;
        int          fd_exp;
        logic [15:0] rd;

        reset   = 1'b1;
        en      = 1'b0;
        restart = 1'b0;
        data_in = 16'h0000;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Free-running scan with 16'h1234 and frame pulse count.
        fd_seen = 0;
        fd_exp  = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 16'h1234);
            if (frame_done === 1'b1) fd_seen++;
            if (((i + 1) % FRAME) == 0) fd_exp++;
        end
        check("fd_pulses", 16'(fd_seen), 16'(fd_exp));
        check("dq_after_wrap", data_q, 16'h1234);

        // New data mid-frame must wait for the next wrap.
        advance_to_sel(1, 16'h1234);
        step(1'b1, 1'b0, 16'h5678);
        check("dq_held", data_q, 16'h1234);
        for (int i = 0; i < 64 && !m_fd; i++) step(1'b1, 1'b0, 16'h5678);
        check("dq_new_frame", data_q, 16'h5678);

        // Disable for 10 cycles at digit 2, then resume.
        advance_to_sel(2, 16'h5678);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h5678);
        check("blank_anode", {12'd0, anode}, 16'h000f);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h5678);

        // Restart coinciding with the 3->0 wrap tick.
        for (int i = 0; i < 64 && m_phase != FRAME - 1; i++) step(1'b1, 1'b0, 16'h5678);
        step(1'b1, 1'b1, 16'h9abc);
        check("restart_no_fd", {15'd0, frame_done}, 16'h0000);
        check("restart_dq", data_q, 16'h9abc);
        check("restart_sel", {14'd0, sel}, 16'h0000);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h9abc);

        // Async reset mid-scan, observed before any clock edge.
        advance_to_sel(2, 16'h9abc);
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        step(1'b1, 1'b0, 16'h1111);
        @(negedge clk);
        reset = 1'b0;

        // Leading-zero pattern.
        step(1'b1, 1'b1, 16'h0042);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h0042);

        // Randomized stimulus, biased towards enabled scanning.
        for (int i = 0; i < 800; i++) begin
            rd = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rd[15:8] = 8'h00;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
